// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART byte transmitter
// among N byte sources. It holds a grant for the rest of a message, up to
// MAX_BURST bytes, inserts idle gaps between bytes, and aborts a stalled byte
// with a watchdog.
//
// Ports
//   Clk, Reset_n          clock, asynchronous active-low reset
//   Req_valid/data/last   per-requester byte stream (data is 8 bits per requester)
//   Req_ack               one-cycle pulse per transmitted byte
//   Tx_en, Tx_data        transmitter enable and byte
//   Tx_done               one-cycle completion pulse from the transmitter
//   Grant                 one-hot current owner, zero when idle
//   Busy                  high outside IDLE
//   Err, Err_cnt          watchdog timeout pulse and saturating count
module uart_tx_arbiter #(
    parameter int unsigned N          = 4,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1_000_000
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic [N-1:0]   Req_valid,
    input  logic [8*N-1:0] Req_data,
    input  logic [N-1:0]   Req_last,
    output logic [N-1:0]   Req_ack,
    output logic           Tx_en,
    output logic [7:0]     Tx_data,
    input  logic           Tx_done,
    output logic [N-1:0]   Grant,
    output logic           Busy,
    output logic           Err,
    output logic [7:0]     Err_cnt
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1) + 1;
    localparam int unsigned WW = 32;
    localparam int unsigned BW = 8;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic            tx_en_q, tx_en_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            last_flag_q, last_flag_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [N-1:0]    req_ack_q, req_ack_d;
    logic            err_q, err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            busy_q, busy_d;

    logic            win_vld_c;
    logic [IW-1:0]   win_c;
    logic            timeout_c;
    logic            gap_last_c;
    logic            cont_c;

    // Round-robin search starting just after the previous owner
    always_comb begin
        win_vld_c = 1'b0;
        win_c     = '0;
        for (int off = 1; off <= int'(N); off++) begin
            if (!win_vld_c && Req_valid[(int'(last_grant_q) + off) % int'(N)]) begin
                win_vld_c = 1'b1;
                win_c     = IW'((int'(last_grant_q) + off) % int'(N));
            end
        end
    end

    assign timeout_c  = (wdog_q == WW'(TIMEOUT - 1));
    // GAP lasts GAP_CYCLES+1 cycles so Tx_en is low that long between bytes
    assign gap_last_c = (gap_cnt_q == GW'(GAP_CYCLES));
    assign cont_c     = Req_valid[owner_q] && !last_flag_q && (burst_cnt_q < BW'(MAX_BURST));

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; Tx_done wins over a coinciding timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (win_vld_c) state_d = S_SEND;
            S_SEND: begin
                if (Tx_done)        state_d = S_GAP;
                else if (timeout_c) state_d = S_IDLE;
            end
            S_GAP:  if (gap_last_c) state_d = cont_c ? S_SEND : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        tx_en_d      = tx_en_q;
        tx_data_d    = tx_data_q;
        last_flag_d  = last_flag_q;
        burst_cnt_d  = burst_cnt_q;
        wdog_d       = wdog_q;
        gap_cnt_d    = gap_cnt_q;
        req_ack_d    = '0;
        err_d        = 1'b0;
        err_cnt_d    = err_cnt_q;
        busy_d       = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (win_vld_c) begin
                    grant_d     = N'(1) << win_c;
                    owner_d     = win_c;
                    tx_data_d   = Req_data[{win_c, 3'b000} +: 8];
                    last_flag_d = Req_last[win_c];
                    burst_cnt_d = BW'(1);
                    wdog_d      = '0;
                    tx_en_d     = 1'b1;
                end
            end
            S_SEND: begin
                wdog_d = wdog_q + WW'(1);
                if (Tx_done) begin
                    tx_en_d   = 1'b0;
                    req_ack_d = grant_q;
                    gap_cnt_d = '0;
                end else if (timeout_c) begin
                    // Abort without ack; the requester keeps its byte and retries
                    tx_en_d      = 1'b0;
                    err_d        = 1'b1;
                    grant_d      = '0;
                    last_grant_d = owner_q;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (gap_last_c) begin
                    if (cont_c) begin
                        tx_data_d   = Req_data[{owner_q, 3'b000} +: 8];
                        last_flag_d = Req_last[owner_q];
                        burst_cnt_d = burst_cnt_q + BW'(1);
                        wdog_d      = '0;
                        tx_en_d     = 1'b1;
                    end else begin
                        grant_d      = '0;
                        last_grant_d = owner_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            grant_q      <= '0;
            owner_q      <= '0;
            last_grant_q <= IW'(N - 1);
            tx_en_q      <= 1'b0;
            tx_data_q    <= '0;
            last_flag_q  <= 1'b0;
            burst_cnt_q  <= '0;
            wdog_q       <= '0;
            gap_cnt_q    <= '0;
            req_ack_q    <= '0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            tx_en_q      <= tx_en_d;
            tx_data_q    <= tx_data_d;
            last_flag_q  <= last_flag_d;
            burst_cnt_q  <= burst_cnt_d;
            wdog_q       <= wdog_d;
            gap_cnt_q    <= gap_cnt_d;
            req_ack_q    <= req_ack_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign Grant   = grant_q;
    assign Req_ack = req_ack_q;
    assign Tx_en   = tx_en_q;
    assign Tx_data = tx_data_q;
    assign Busy    = busy_q;
    assign Err     = err_q;
    assign Err_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester sources, a transmitter model
// that answers Tx_done a fixed delay after Tx_en rises, and a monitor that logs
// sent bytes, grants, acks and errors.
module tb_uart_tx_arbiter;
    localparam int unsigned N      = 4;
    localparam int unsigned TX_DLY = 20;

    logic           Clk = 1'b0;
    logic           Reset_n;
    logic [N-1:0]   Req_valid;
    logic [8*N-1:0] Req_data;
    logic [N-1:0]   Req_last;
    logic [N-1:0]   Req_ack;
    logic           Tx_en;
    logic [7:0]     Tx_data;
    logic           Tx_done;
    logic [N-1:0]   Grant;
    logic           Busy;
    logic           Err;
    logic [7:0]     Err_cnt;

    uart_tx_arbiter #(.N(N), .MAX_BURST(16), .GAP_CYCLES(2), .TIMEOUT(100)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req_valid(Req_valid), .Req_data(Req_data), .Req_last(Req_last),
        .Req_ack(Req_ack), .Tx_en(Tx_en), .Tx_data(Tx_data), .Tx_done(Tx_done),
        .Grant(Grant), .Busy(Busy), .Err(Err), .Err_cnt(Err_cnt)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Source model
    logic [7:0] src_data [N][64];
    bit         src_last [N][64];
    int         src_len  [N];
    int         src_ptr  [N];

    // Monitor state
    logic [7:0] sent_q[$];
    int         gap_q[$];
    int         grant_log[$];
    int         ack_cnt [N];
    int         err_n, err_cyc, rise_cyc, cyc, low_len, tx_cnt;
    bit         tx_auto;
    logic       tx_en_prev;
    logic [N-1:0] grant_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < int'(N); i++) begin
            if (src_ptr[i] < src_len[i]) begin
                Req_valid[i]       = 1'b1;
                Req_data[8*i +: 8] = src_data[i][src_ptr[i]];
                Req_last[i]        = src_last[i][src_ptr[i]];
            end else begin
                Req_valid[i]       = 1'b0;
                Req_data[8*i +: 8] = 8'h00;
                Req_last[i]        = 1'b0;
            end
        end
    endtask

    // One clock: sample #1 after the edge, update models, drive inputs
    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
        for (int i = 0; i < int'(N); i++)
            if (Req_ack[i]) begin ack_cnt[i]++; src_ptr[i]++; end
        if (Err) begin err_n++; err_cyc = cyc; end
        if (Tx_en && !tx_en_prev) begin
            sent_q.push_back(Tx_data);
            gap_q.push_back(low_len);
            rise_cyc = cyc;
        end
        low_len = Tx_en ? 0 : low_len + 1;
        if (Grant != '0 && grant_prev == '0) begin
            chk("grant_onehot", 32'($onehot(Grant)), 32'd1);
            for (int i = 0; i < int'(N); i++) if (Grant[i]) grant_log.push_back(i);
        end
        tx_en_prev = Tx_en;
        grant_prev = Grant;
        if (tx_auto) begin
            tx_cnt  = Tx_en ? tx_cnt + 1 : 0;
            Tx_done = Tx_en && (tx_cnt == TX_DLY);
        end
        drive_src();
    endtask

    task automatic clr();
        sent_q.delete(); gap_q.delete(); grant_log.delete();
        for (int i = 0; i < int'(N); i++) begin
            ack_cnt[i] = 0; src_len[i] = 0; src_ptr[i] = 0;
        end
        err_n = 0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        step(); step();
        Reset_n = 1'b1;
        step();
    endtask

    task automatic put(input int r, input logic [7:0] d, input bit l);
        src_data[r][src_len[r]] = d;
        src_last[r][src_len[r]] = l;
        src_len[r]++;
    endtask

    task automatic wait_acks(input int total, input int bound);
        int k = 0;
        int s = 0;
        do begin
            s = 0;
            for (int i = 0; i < int'(N); i++) s += ack_cnt[i];
            if (s < total) begin step(); k++; end
        end while (s < total && k < bound);
        chk("ack_wait", 32'(s >= total), 32'd1);
    endtask

    task automatic wait_rise(input int bound);
        int n0 = sent_q.size();
        int k  = 0;
        while (sent_q.size() == n0 && k < bound) begin step(); k++; end
        chk("rise_wait", 32'(sent_q.size() > n0), 32'd1);
    endtask

    task automatic wait_err(input int n, input int bound);
        int k = 0;
        while (err_n < n && k < bound) begin step(); k++; end
        chk("err_wait", 32'(err_n >= n), 32'd1);
    endtask

    logic [7:0] exp_b[$];
    int         r0;

    initial begin
        Reset_n = 1'b0; Req_valid = '0; Req_data = '0; Req_last = '0; Tx_done = 1'b0;
        tx_auto = 1'b1; tx_cnt = 0; cyc = 0; low_len = 0; err_cyc = 0; rise_cyc = 0;
        tx_en_prev = 1'b0; grant_prev = '0;
        clr();
        #3;
        chk("rst_grant", 32'(Grant), 32'd0);
        chk("rst_tx_en", 32'(Tx_en), 32'd0);
        chk("rst_tx_data", 32'(Tx_data), 32'd0);
        chk("rst_ack", 32'(Req_ack), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_err_cnt", 32'(Err_cnt), 32'd0);
        step();
        Reset_n = 1'b1;
        step();

        // Single requester, 3-byte message
        clr();
        put(0, 8'h55, 0); put(0, 8'hA3, 0); put(0, 8'h0F, 1);
        drive_src();
        step();
        chk("t1_latency_en", 32'(Tx_en), 32'd1);
        chk("t1_latency_grant", 32'(Grant), 32'd1);
        chk("t1_busy", 32'(Busy), 32'd1);
        wait_acks(3, 500);
        repeat (4) step();
        chk("t1_nbytes", 32'(sent_q.size()), 32'd3);
        if (sent_q.size() == 3) begin
            chk("t1_b0", 32'(sent_q[0]), 32'h55);
            chk("t1_b1", 32'(sent_q[1]), 32'hA3);
            chk("t1_b2", 32'(sent_q[2]), 32'h0F);
            chk("t1_gap1", 32'(gap_q[1]), 32'd3);
            chk("t1_gap2", 32'(gap_q[2]), 32'd3);
        end
        chk("t1_acks", 32'(ack_cnt[0]), 32'd3);
        chk("t1_released", 32'(Grant), 32'd0);
        chk("t1_idle", 32'(Busy), 32'd0);

        // Four requesters from reset, requester 0 re-requests
        do_reset();
        clr();
        put(0, 8'h10, 1); put(0, 8'h11, 1);
        put(1, 8'h21, 1); put(2, 8'h32, 1); put(3, 8'h43, 1);
        drive_src();
        wait_acks(5, 1000);
        repeat (4) step();
        chk("t2_ngrants", 32'(grant_log.size()), 32'd5);
        if (grant_log.size() == 5) begin
            chk("t2_g0", 32'(grant_log[0]), 32'd0);
            chk("t2_g1", 32'(grant_log[1]), 32'd1);
            chk("t2_g2", 32'(grant_log[2]), 32'd2);
            chk("t2_g3", 32'(grant_log[3]), 32'd3);
            chk("t2_g4", 32'(grant_log[4]), 32'd0);
            chk("t2_b4", 32'(sent_q[4]), 32'h11);
        end

        // Burst limit: 40-byte stream on 1, 3-byte message waiting on 2
        do_reset();
        clr();
        for (int i = 0; i < 40; i++) put(1, 8'(8'h40 + i), i == 39);
        put(2, 8'hB0, 0); put(2, 8'hB1, 0); put(2, 8'hB2, 1);
        drive_src();
        wait_acks(43, 3000);
        repeat (4) step();
        exp_b.delete();
        for (int i = 0; i < 16; i++) exp_b.push_back(8'(8'h40 + i));
        exp_b.push_back(8'hB0); exp_b.push_back(8'hB1); exp_b.push_back(8'hB2);
        for (int i = 16; i < 40; i++) exp_b.push_back(8'(8'h40 + i));
        chk("t3_nbytes", 32'(sent_q.size()), 32'd43);
        if (sent_q.size() == 43)
            for (int i = 0; i < 43; i++) chk($sformatf("t3_b%0d", i), 32'(sent_q[i]), 32'(exp_b[i]));
        chk("t3_ngrants", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            chk("t3_g0", 32'(grant_log[0]), 32'd1);
            chk("t3_g1", 32'(grant_log[1]), 32'd2);
            chk("t3_g2", 32'(grant_log[2]), 32'd1);
            chk("t3_g3", 32'(grant_log[3]), 32'd1);
        end

        // Async reset mid-byte, retransmission, stray Tx_done in IDLE
        do_reset();
        clr();
        put(0, 8'h3C, 1);
        drive_src();
        wait_rise(50);
        repeat (5) step();
        #2 Reset_n = 1'b0;
        #1;
        chk("t4_async_tx_en", 32'(Tx_en), 32'd0);
        chk("t4_async_grant", 32'(Grant), 32'd0);
        chk("t4_async_busy", 32'(Busy), 32'd0);
        step(); step();
        Reset_n = 1'b1;
        wait_acks(1, 200);
        repeat (4) step();
        chk("t4_nbytes", 32'(sent_q.size()), 32'd2);
        if (sent_q.size() == 2) chk("t4_resend", 32'(sent_q[1]), 32'h3C);
        chk("t4_acks", 32'(ack_cnt[0]), 32'd1);
        tx_auto = 1'b0;
        Tx_done = 1'b1;
        step();
        Tx_done = 1'b0;
        repeat (3) step();
        chk("t4_stray_ack", 32'(ack_cnt[0]), 32'd1);
        chk("t4_stray_busy", 32'(Busy), 32'd0);

        // Watchdog with no Tx_done, then saturation of Err_cnt
        do_reset();
        clr();
        put(0, 8'h99, 1);
        drive_src();
        wait_rise(50);
        r0 = rise_cyc;
        wait_err(1, 200);
        chk("t5_err_delay", 32'(err_cyc - r0), 32'd100);
        chk("t5_err_cnt1", 32'(Err_cnt), 32'd1);
        chk("t5_tx_en_off", 32'(Tx_en), 32'd0);
        chk("t5_no_ack", 32'(ack_cnt[0]), 32'd0);
        wait_rise(50);
        chk("t5_retry_byte", 32'(Tx_data), 32'h99);
        wait_err(300, 35000);
        step();
        chk("t5_err_pulse", 32'(Err), 32'd0);
        chk("t5_err_sat", 32'(Err_cnt), 32'd255);
        chk("t5_no_ack_end", 32'(ack_cnt[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
